// File: rtl/stream_fifo.sv
// Show-ahead byte-stream buffer with valid/ready on both sides, occupancy
// output and free-running accepted/delivered beat counters.
module stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_WIDTH-1:0]       in_beats,
    output logic [CNT_WIDTH-1:0]       out_beats
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic [CNT_WIDTH-1:0]  in_beats_reg;
    logic [CNT_WIDTH-1:0]  out_beats_reg;
    logic                  push;
    logic                  pop;

    // Status is derived only from registered occupancy, so neither ready nor
    // valid ever depends combinationally on the opposite handshake input.
    assign i_ready   = (count_reg != CW'(DEPTH));
    assign o_valid   = (count_reg != '0);
    assign o_data    = mem_reg[rd_ptr_reg];
    assign count     = count_reg;
    assign in_beats  = in_beats_reg;
    assign out_beats = out_beats_reg;

    assign push = i_valid && i_ready;
    assign pop  = o_valid && o_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Each entry is its own register so the whole array clears on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            in_beats_reg  <= '0;
            out_beats_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                in_beats_reg <= in_beats_reg + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                out_beats_reg <= out_beats_reg + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: directed fill/drain/latency/reset
// scenarios followed by a randomized handshake stress run.
module tb_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clock;
    logic            reset;
    logic            i_valid;
    logic            i_ready;
    logic [DW-1:0]   i_data;
    logic            o_valid;
    logic            o_ready;
    logic [DW-1:0]   o_data;
    logic [CW-1:0]   count;
    logic [CNTW-1:0] in_beats;
    logic [CNTW-1:0] out_beats;

    int              compared;
    int              mismatched;
    bit              verbose;

    logic [DW-1:0]   sb[$];
    int              m_count;
    logic [CNTW-1:0] m_in;
    logic [CNTW-1:0] m_out;

    stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .count     (count),
        .in_beats  (in_beats),
        .out_beats (out_beats)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock: check registered outputs against the model, take the edge,
    // then retire the handshakes the model predicts.
    task automatic step();
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [DW-1:0] head;
        push = i_valid && (m_count != DEPTH);
        pop  = o_ready && (m_count != 0);
        din  = i_data;
        head = (sb.size() != 0) ? sb[0] : '0;
        compared++;
        if (i_ready !== (m_count != DEPTH)) begin
            mismatched++;
            $display("FAIL i_ready: got %b expected %b", i_ready, (m_count != DEPTH));
        end
        compared++;
        if (o_valid !== (m_count != 0)) begin
            mismatched++;
            $display("FAIL o_valid: got %b expected %b", o_valid, (m_count != 0));
        end
        compared++;
        if (count !== CW'(m_count)) begin
            mismatched++;
            $display("FAIL count: got %0d expected %0d", count, m_count);
        end
        if (m_count != 0) begin
            compared++;
            if (o_data !== head) begin
                mismatched++;
                $display("FAIL o_data: got %02h expected %02h", o_data, head);
            end
        end
        @(posedge clock);
        #1;
        if (push) begin
            sb.push_back(din);
            m_in++;
            m_count++;
            if (verbose) $display("push %02h count=%0d", din, m_count);
        end
        if (pop) begin
            void'(sb.pop_front());
            m_out++;
            m_count--;
            if (verbose) $display("pop  %02h count=%0d", head, m_count);
        end
        compared++;
        if (in_beats !== m_in) begin
            mismatched++;
            $display("FAIL in_beats: got %0d expected %0d", in_beats, m_in);
        end
        compared++;
        if (out_beats !== m_out) begin
            mismatched++;
            $display("FAIL out_beats: got %0d expected %0d", out_beats, m_out);
        end
        compared++;
        if ((in_beats - out_beats) !== CNTW'(count)) begin
            mismatched++;
            $display("FAIL invariant: in-out %0d count %0d", in_beats - out_beats, count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        compared++;
        if ({i_ready, o_valid, o_data, count} !== {1'b1, 1'b0, DW'(0), CW'(0)}) begin
            mismatched++;
            $display("FAIL %s outputs: got rdy=%b vld=%b data=%02h cnt=%0d expected 1 0 00 0",
                     tag, i_ready, o_valid, o_data, count);
        end
        compared++;
        if ((in_beats !== '0) || (out_beats !== '0)) begin
            mismatched++;
            $display("FAIL %s counters: got in=%0d out=%0d expected 0 0", tag, in_beats, out_beats);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_count = 0;
        m_in    = '0;
        m_out   = '0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hEE;
        o_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset_held");
        i_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check_reset_outputs("reset_release");
        $display("reset done");
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        o_ready = 1'b0;
        i_valid = 1'b1;
        foreach (vals[i]) begin
            i_data = vals[i];
            step();
        end
        i_data = 8'h55;
        repeat (2) step();
        compared++;
        if ((count !== CW'(4)) || (i_ready !== 1'b0)) begin
            mismatched++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b expected 4 0", count, i_ready);
        end
        compared++;
        if ((o_data !== 8'h11) || (in_beats !== 32'd4)) begin
            mismatched++;
            $display("FAIL fill_hold: got data=%02h in=%0d expected 11 4", o_data, in_beats);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_drain();
        o_ready = 1'b1;
        step();
        compared++;
        if (i_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL drain_ready_rise: got %b expected 1", i_ready);
        end
        repeat (3) step();
        compared++;
        if ((o_valid !== 1'b0) || (out_beats !== 32'd4)) begin
            mismatched++;
            $display("FAIL drain_end: got vld=%b out=%0d expected 0 4", o_valid, out_beats);
        end
        o_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [CNTW-1:0] out0;
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h60;
        step();
        i_data  = 8'h61;
        step();
        out0    = out_beats;
        o_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_data = DW'(8'h70 + i);
            step();
            compared++;
            if (count !== CW'(2)) begin
                mismatched++;
                $display("FAIL b2b_count cycle %0d: got %0d expected 2", i, count);
            end
        end
        compared++;
        if (((in_beats - out_beats) !== 32'd2) || ((out_beats - out0) !== 32'd10)) begin
            mismatched++;
            $display("FAIL b2b_totals: got diff=%0d moved=%0d expected 2 10",
                     in_beats - out_beats, out_beats - out0);
        end
        i_valid = 1'b0;
        repeat (2) step();
        o_ready = 1'b0;
    endtask

    task automatic test_empty_latency();
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hA5;
        compared++;
        if (o_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_pre: got vld=%b expected 0", o_valid);
        end
        step();
        i_valid = 1'b0;
        compared++;
        if ((o_valid !== 1'b1) || (o_data !== 8'hA5)) begin
            mismatched++;
            $display("FAIL latency_out: got vld=%b data=%02h expected 1 a5", o_valid, o_data);
        end
        step();
        compared++;
        if (o_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_once: got vld=%b expected 0", o_valid);
        end
        o_ready = 1'b0;
    endtask

    task automatic test_midstream_reset();
        o_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = DW'(8'hC0 + i);
            step();
        end
        compared++;
        if (count !== CW'(3)) begin
            mismatched++;
            $display("FAIL midreset_pre: got cnt=%0d expected 3", count);
        end
        // Assert between edges: the clear must not wait for the clock.
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_clear();
        i_valid = 1'b0;
        #1;
        reset = 1'b0;
        $display("midstream reset done");
    endtask

    task automatic test_random();
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            i_data  = DW'($urandom);
            step();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (DEPTH + 1) step();
        compared++;
        if ((o_valid !== 1'b0) || (in_beats !== out_beats)) begin
            mismatched++;
            $display("FAIL random_end: got vld=%b in=%0d out=%0d", o_valid, in_beats, out_beats);
        end
        $display("random stress done: %0d beats", out_beats);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        verbose    = 1'b1;
        i_valid    = 1'b0;
        o_ready    = 1'b0;
        i_data     = '0;
        reset      = 1'b1;
        #3;
        test_reset();
        @(posedge clock);
        #1;
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_latency();
        test_midstream_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
